// File: rtl/uart_txq_pkg.sv
// uart_txq_pkg: shared types and constants for the UART transmit queue.
//   - txq_state_e : launch sequencer states
//   - BYTE_W      : data byte width
//   - *_DEF       : default timing constants for the sequencer
//   - CNT_W       : sequencer cycle counter width (timing parameters must fit)
package uart_txq_pkg;

   localparam int unsigned BYTE_W            = 8;
   localparam int unsigned STROBE_CYC_DEF    = 2;
   localparam int unsigned START_TIMEOUT_DEF = 8;
   localparam int unsigned GAP_CYC_DEF       = 2;
   localparam int unsigned CNT_W             = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STROBE,
      WAIT_BUSY,
      WAIT_DONE,
      GAP
   } txq_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: byte-write and transmitter-side signals of the UART transmit queue.
//   master : upstream/environment side (drives writes, tx_busy, ovf_clr)
//   slave  : queue side (drives flags, tx_data, tx_wrsig, ovf, active)
interface uart_tx_queue_if #(
   parameter int unsigned AW = 4
) ();
   import uart_txq_pkg::*;

   logic              wr_en;
   logic [BYTE_W-1:0] wr_data;
   logic              full;
   logic              empty;
   logic [AW:0]       count;
   logic [BYTE_W-1:0] tx_data;
   logic              tx_wrsig;
   logic              tx_busy;
   logic              ovf;
   logic              ovf_clr;
   logic              active;

   modport master (
      output wr_en, wr_data, tx_busy, ovf_clr,
      input  full, empty, count, tx_data, tx_wrsig, ovf, active
   );

   modport slave (
      input  wr_en, wr_data, tx_busy, ovf_clr,
      output full, empty, count, tx_data, tx_wrsig, ovf, active
   );

endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: single-clock byte FIFO with registered full/empty/count.
//   clk, rst_n : clock, async active-low reset
//   i_wr       : write request (ignored while full)
//   i_wdata    : byte to store
//   i_rd       : pop request (ignored while empty)
//   o_rdata    : current head byte
//   o_full     : DEPTH bytes held
//   o_empty    : no bytes held
//   o_count    : bytes held
module uart_byte_fifo
   import uart_txq_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr,
   input  logic [BYTE_W-1:0] i_wdata,
   input  logic              i_rd,
   output logic [BYTE_W-1:0] o_rdata,
   output logic              o_full,
   output logic              o_empty,
   output logic [AW:0]       o_count
);

   localparam logic [AW:0] L_FULL_CNT = (AW+1)'(DEPTH);

   logic [BYTE_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;
   logic              r_full;
   logic              r_empty;
   logic [AW:0]       w_count_d;
   logic              w_wr;
   logic              w_rd;

   // A write while full is dropped even if a pop frees a slot this cycle.
   assign w_wr = i_wr & ~r_full;
   assign w_rd = i_rd & ~r_empty;

   always_comb begin
      w_count_d = r_count;
      if (w_wr && !w_rd) begin
         w_count_d = r_count + 1'b1;
      end else if (!w_wr && w_rd) begin
         w_count_d = r_count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         r_count <= w_count_d;
         r_full  <= (w_count_d == L_FULL_CNT);
         r_empty <= (w_count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;
   assign o_count = r_count;

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue and launch sequencer in front of a UART transmitter.
//   clk, rst_n : UART clock, async active-low reset
//   bus        : uart_tx_queue_if.slave
//                wr_en/wr_data in, full/empty/count out, tx_data/tx_wrsig out,
//                tx_busy in, ovf out, ovf_clr in, active out
// Optional: define UART_TXQ_OVF_EN for a sticky overflow flag on dropped writes;
// otherwise ovf is tied low and ovf_clr is ignored.
module uart_tx_queue
   import uart_txq_pkg::*;
#(
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned AW            = 4,
   parameter int unsigned STROBE_CYC    = STROBE_CYC_DEF,
   parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEF,
   parameter int unsigned GAP_CYC       = GAP_CYC_DEF
) (
   input logic            clk,
   input logic            rst_n,
   uart_tx_queue_if.slave bus
);

   localparam logic [CNT_W-1:0] L_STROBE_LAST  = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] L_TIMEOUT_LAST = CNT_W'(START_TIMEOUT - 1);
   // Unused when GAP_CYC is 0: the GAP state is never entered.
   localparam logic [CNT_W-1:0] L_GAP_LAST     = CNT_W'(GAP_CYC - 1);

   logic [BYTE_W-1:0] w_rdata;
   logic              w_full;
   logic              w_empty;
   logic [AW:0]       w_count;
   logic              w_pop;

   txq_state_e        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [BYTE_W-1:0] r_tx_data;
   logic              r_wrsig;
   logic              r_active;

   assign w_pop = (r_state == LOAD);

   uart_byte_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr    (bus.wr_en),
      .i_wdata (bus.wr_data),
      .i_rd    (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // tx_wrsig is only set on entry to STROBE from LOAD or WAIT_BUSY, both of which hold it
   // low for at least one cycle, so every strobe is a clean rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_tx_data <= '0;
         r_wrsig   <= 1'b0;
         r_active  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (!w_empty && !bus.tx_busy) begin
                  r_state  <= LOAD;
                  r_active <= 1'b1;
               end
            end
            LOAD: begin
               r_tx_data <= w_rdata;
               r_wrsig   <= 1'b1;
               r_cnt     <= '0;
               r_state   <= STROBE;
            end
            STROBE: begin
               if (r_cnt == L_STROBE_LAST) begin
                  r_wrsig <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= WAIT_BUSY;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  r_state <= WAIT_DONE;
               end else if (r_cnt == L_TIMEOUT_LAST) begin
                  // Transmitter missed the strobe: launch the same byte again.
                  r_wrsig <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= STROBE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  r_cnt <= '0;
                  if (GAP_CYC == 0) begin
                     r_state  <= IDLE;
                     r_active <= 1'b0;
                  end else begin
                     r_state <= GAP;
                  end
               end
            end
            GAP: begin
               if (r_cnt == L_GAP_LAST) begin
                  r_state  <= IDLE;
                  r_active <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_wrsig  <= 1'b0;
               r_active <= 1'b0;
            end
         endcase
      end
   end

`ifdef UART_TXQ_OVF_EN
   logic w_drop;
   logic r_ovf;

   assign w_drop = bus.wr_en & w_full;

   // Clear takes priority over a drop in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (bus.ovf_clr) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end
   end

   assign bus.ovf = r_ovf;
`else
   logic w_unused_ovf_clr;
   assign w_unused_ovf_clr = bus.ovf_clr;
   assign bus.ovf          = 1'b0;
`endif

   assign bus.full     = w_full;
   assign bus.empty    = w_empty;
   assign bus.count    = w_count;
   assign bus.tx_data  = r_tx_data;
   assign bus.tx_wrsig = r_wrsig;
   assign bus.active   = r_active;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed self-checking bench for uart_tx_queue with a
// 16 clk/bit transmitter model (start, 8 data LSB-first, even parity, stop).
module tb_uart_tx_queue;
   import uart_txq_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_queue_if #(.AW(4)) u_if ();

   uart_tx_queue #(
      .DEPTH         (16),
      .AW            (4),
      .STROBE_CYC    (2),
      .START_TIMEOUT (8),
      .GAP_CYC       (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Transmitter model
   logic        m_en;
   logic        force_busy;
   logic        m_busy;
   logic        m_wr_q;
   logic [7:0]  m_cyc;
   logic [10:0] m_cap;
   logic        m_line;
   logic [3:0]  m_bit;
   logic [10:0] frames[$];

   assign u_if.tx_busy = m_busy | force_busy;

   always_comb begin
      m_bit  = m_cyc[7:4];
      m_line = 1'b1;
      if (m_busy) begin
         if (m_bit == 4'd0)      m_line = 1'b0;
         else if (m_bit <= 4'd8) m_line = u_if.tx_data[3'(m_bit - 4'd1)];
         else if (m_bit == 4'd9) m_line = ^u_if.tx_data;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_cyc  <= 8'd0;
         m_wr_q <= 1'b0;
         m_cap  <= 11'd0;
      end else begin
         m_wr_q <= u_if.tx_wrsig;
         if (!m_busy) begin
            if (m_en && u_if.tx_wrsig && !m_wr_q) begin
               m_busy <= 1'b1;
               m_cyc  <= 8'd0;
            end
         end else begin
            if (m_cyc[3:0] == 4'd8) m_cap[m_cyc[7:4]] <= m_line;
            if (m_cyc == 8'd175) begin
               m_busy <= 1'b0;
               frames.push_back(m_cap);
            end
            m_cyc <= m_cyc + 8'd1;
         end
      end
   end

   // Monitor: strobe count and busy-fall to strobe-rise spacing
   int   cyc = 0;
   int   n_strobe = 0;
   int   fall_cyc = 0;
   bit   fall_seen = 1'b0;
   logic mon_busy_q;
   logic mon_wr_q;
   int   deltas[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (m_busy === 1'b0 && mon_busy_q === 1'b1) begin
         fall_cyc  = cyc;
         fall_seen = 1'b1;
      end
      if (u_if.tx_wrsig === 1'b1 && mon_wr_q === 1'b0) begin
         n_strobe++;
         if (fall_seen) begin
            deltas.push_back(cyc - fall_cyc);
            fall_seen = 1'b0;
         end
      end
      mon_busy_q = m_busy;
      mon_wr_q   = u_if.tx_wrsig;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [7:0] b);
      u_if.wr_en   = 1'b1;
      u_if.wr_data = b;
      tick();
      u_if.wr_en   = 1'b0;
   endtask

   task automatic wait_frames(input int n, input int limit, input string tag);
      int k = 0;
      while (frames.size() < n && k < limit) begin
         tick();
         k++;
      end
      check(tag, 32'(frames.size()), 32'(n));
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (u_if.active !== 1'b0 && k < 50) begin
         tick();
         k++;
      end
      check(tag, 32'(u_if.active), 32'd0);
   endtask

   function automatic logic [10:0] frame_of(input logic [7:0] b);
      return {1'b1, ^b, b, 1'b0};
   endfunction

   logic exp_ovf;
   int   fb;
   int   bd;
   int   s0;
   int   k;

   initial begin
`ifdef UART_TXQ_OVF_EN
      exp_ovf = 1'b1;
`else
      exp_ovf = 1'b0;
`endif
      u_if.wr_en   = 1'b0;
      u_if.wr_data = 8'h00;
      u_if.ovf_clr = 1'b0;
      force_busy   = 1'b0;
      m_en         = 1'b1;
      rst_n        = 1'b0;
      #12;
      check("rst_full",   32'(u_if.full),     32'd0);
      check("rst_empty",  32'(u_if.empty),    32'd1);
      check("rst_count",  32'(u_if.count),    32'd0);
      check("rst_txdata", 32'(u_if.tx_data),  32'h00);
      check("rst_wrsig",  32'(u_if.tx_wrsig), 32'd0);
      check("rst_ovf",    32'(u_if.ovf),      32'd0);
      check("rst_active", 32'(u_if.active),   32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single byte A5
      fb = frames.size();
      wr(8'hA5);
      check("a5_count_e0", 32'(u_if.count),    32'd1);
      check("a5_wrsig_e0", 32'(u_if.tx_wrsig), 32'd0);
      tick();
      check("a5_wrsig_e1", 32'(u_if.tx_wrsig), 32'd0);
      check("a5_active",   32'(u_if.active),   32'd1);
      tick();
      check("a5_wrsig_e2", 32'(u_if.tx_wrsig), 32'd1);
      check("a5_txdata",   32'(u_if.tx_data),  32'hA5);
      check("a5_count_e2", 32'(u_if.count),    32'd0);
      check("a5_empty_e2", 32'(u_if.empty),    32'd1);
      tick();
      check("a5_wrsig_e3", 32'(u_if.tx_wrsig), 32'd1);
      tick();
      check("a5_wrsig_e4", 32'(u_if.tx_wrsig), 32'd0);
      wait_frames(fb + 1, 400, "a5_frame_done");
      check("a5_frame",    32'(frames[fb]),    32'(11'b1_0_1010_0101_0));
      check("a5_hold",     32'(u_if.tx_data),  32'hA5);
      wait_idle("a5_idle");

      // Burst 01..10 with transmitter held busy, then overflow
      force_busy = 1'b1;
      for (int i = 1; i <= 16; i++) wr(8'(i));
      check("burst_full",   32'(u_if.full),   32'd1);
      check("burst_count",  32'(u_if.count),  32'd16);
      check("burst_empty",  32'(u_if.empty),  32'd0);
      check("burst_active", 32'(u_if.active), 32'd0);
      wr(8'hEE);
      check("drop_count",   32'(u_if.count),  32'd16);
      check("drop_ovf",     32'(u_if.ovf),    32'(exp_ovf));
      u_if.ovf_clr = 1'b1;
      tick();
      u_if.ovf_clr = 1'b0;
      check("ovf_clr",      32'(u_if.ovf),    32'd0);

      // Release: write lands in the LOAD (pop) cycle while full
      bd = deltas.size();
      fb = frames.size();
      force_busy = 1'b0;
      tick();
      check("rel_active",   32'(u_if.active), 32'd1);
      u_if.wr_en   = 1'b1;
      u_if.wr_data = 8'hEE;
      tick();
      u_if.wr_en   = 1'b0;
      check("fullpop_count", 32'(u_if.count),    32'd15);
      check("fullpop_full",  32'(u_if.full),     32'd0);
      check("fullpop_wrsig", 32'(u_if.tx_wrsig), 32'd1);
      check("fullpop_data",  32'(u_if.tx_data),  32'h01);
      check("fullpop_ovf",   32'(u_if.ovf),      32'(exp_ovf));
      wait_frames(fb + 16, 3600, "burst_frames_done");
      for (int i = 0; i < 16; i++)
         check("burst_frame", 32'(frames[fb + i]), 32'(frame_of(8'(i + 1))));
      check("burst_nstrobe_gaps", 32'(deltas.size()), 32'(bd + 16));
      for (int i = 1; i < 16; i++)
         check("burst_gap5", 32'(deltas[bd + i]), 32'd5);
      wait_idle("burst_idle");
      check("burst_no_extra", 32'(frames.size()), 32'(fb + 16));

      // Unresponsive transmitter: re-strobe after timeout
      m_en = 1'b0;
      fb = frames.size();
      wr(8'h3C);
      wr(8'h5A);
      check("to_count_e1", 32'(u_if.count),    32'd2);
      tick();
      check("to_wrsig_e2", 32'(u_if.tx_wrsig), 32'd1);
      check("to_count_e2", 32'(u_if.count),    32'd1);
      tick();
      tick();
      check("to_wrsig_e4", 32'(u_if.tx_wrsig), 32'd0);
      repeat (7) tick();
      check("to_wrsig_e11", 32'(u_if.tx_wrsig), 32'd0);
      tick();
      check("to_restrobe",  32'(u_if.tx_wrsig), 32'd1);
      check("to_data",      32'(u_if.tx_data),  32'h3C);
      check("to_count",     32'(u_if.count),    32'd1);
      m_en = 1'b1;
      wait_frames(fb + 2, 600, "to_frames_done");
      check("to_frame0", 32'(frames[fb]),     32'(11'b1_0_0011_1100_0));
      check("to_frame1", 32'(frames[fb + 1]), 32'(11'b1_0_0101_1010_0));
      wait_idle("to_idle");

      // Reset during WAIT_DONE with 5 bytes queued
      fb = frames.size();
      for (int i = 0; i < 6; i++) wr(8'(8'h11 + i));
      k = 0;
      while (u_if.tx_busy !== 1'b1 && k < 50) begin
         tick();
         k++;
      end
      check("mid_busy",   32'(u_if.tx_busy), 32'd1);
      repeat (3) tick();
      check("mid_count",  32'(u_if.count),   32'd5);
      check("mid_active", 32'(u_if.active),  32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_full",   32'(u_if.full),     32'd0);
      check("mrst_empty",  32'(u_if.empty),    32'd1);
      check("mrst_count",  32'(u_if.count),    32'd0);
      check("mrst_txdata", 32'(u_if.tx_data),  32'h00);
      check("mrst_wrsig",  32'(u_if.tx_wrsig), 32'd0);
      check("mrst_ovf",    32'(u_if.ovf),      32'd0);
      check("mrst_active", 32'(u_if.active),   32'd0);
      tick();
      rst_n = 1'b1;
      s0 = n_strobe;
      repeat (100) tick();
      check("mrst_no_strobe", 32'(n_strobe),      32'(s0));
      check("mrst_no_frame",  32'(frames.size()), 32'(fb));
      check("mrst_empty2",    32'(u_if.empty),    32'd1);

      // Simultaneous write and pop at count 3
      force_busy = 1'b1;
      wr(8'h21);
      wr(8'h22);
      wr(8'h23);
      check("wp_count3", 32'(u_if.count), 32'd3);
      fb = frames.size();
      force_busy = 1'b0;
      tick();
      wr(8'h24);
      check("wp_count_same", 32'(u_if.count),   32'd3);
      check("wp_data",       32'(u_if.tx_data), 32'h21);
      wait_frames(fb + 4, 1000, "wp_frames_done");
      for (int i = 0; i < 4; i++)
         check("wp_frame", 32'(frames[fb + i]), 32'(frame_of(8'(8'h21 + i))));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Byte queue and launch sequencer that sits directly upstream of the UART transmitter.
- Accepts bytes from the frame/packet logic into a FIFO.
- Presents one byte at a time on the transmitter's data input and raises its send strobe with the required rising edge.
- Holds the data stable for the whole frame and waits for the transmitter's busy indication to clear before launching the next byte.
- Runs on the UART clock (16 clocks per bit).

Parameters:
DEPTH, 16, FIFO depth in bytes; power of two, minimum 2.
AW, 4, address width; log2(DEPTH).
STROBE_CYC, 2, cycles tx_wrsig is held high per launch; minimum 1.
START_TIMEOUT, 8, cycles to wait for tx_busy high after a strobe before re-strobing; must be at least 4.
GAP_CYC, 2, idle cycles inserted after tx_busy falls before the next launch; 0 allowed.

Ports:
clk  in  1  UART clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  write request for wr_data.
wr_data  in  8  byte to enqueue.
full  out  1  FIFO holds DEPTH bytes.
empty  out  1  FIFO holds 0 bytes.
count  out  AW+1  bytes currently queued, excluding the byte in flight.
tx_data  out  8  to transmitter datain; stable from LOAD until the next LOAD.
tx_wrsig  out  1  to transmitter wrsig; launch strobe.
tx_busy  in  1  from transmitter idle output; 1 = line busy, 0 = line free.
ovf  out  1  sticky overflow flag (see Optional Feature).
ovf_clr  in  1  clears ovf.
active  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n=0): FIFO pointers and count cleared; full=0, empty=1, count=0, tx_data=8'h00, tx_wrsig=0, ovf=0, active=0, state=IDLE.
- A reset mid-frame abandons the in-flight byte and all queued bytes.
- Write rule:
  - wr_en with full=0: byte stored; count increments the next cycle.
  - wr_en with full=1: byte dropped, even if a pop occurs in the same cycle.
  - Simultaneous accepted write and pop: count unchanged.
- Flags: full, empty and count are registered and consistent with each other every cycle. Pointers wrap modulo DEPTH.
- State machine (registered):
  - IDLE: if empty=0 and tx_busy=0 -> LOAD.
  - LOAD: pop FIFO head into tx_data; -> STROBE. One cycle.
  - STROBE: tx_wrsig=1 for STROBE_CYC cycles; -> WAIT_BUSY with tx_wrsig=0.
  - WAIT_BUSY: tx_wrsig=0. If tx_busy=1 -> WAIT_DONE. If START_TIMEOUT cycles elapse without tx_busy -> STROBE (re-strobe; tx_data unchanged, no further pop).
  - WAIT_DONE: wait for tx_busy=0 -> GAP.
  - GAP: count GAP_CYC cycles, then -> IDLE. If GAP_CYC=0, go directly to IDLE.
- tx_wrsig:
  - Guaranteed low for at least 1 cycle before every strobe, so the transmitter always sees a rising edge.
  - Never high outside STROBE.
- Latency:
  - From a write into an empty FIFO with the line free, tx_wrsig rises 3 cycles later (write registered, IDLE decision, LOAD).
  - Back-to-back frames are separated by GAP_CYC + 3 cycles after tx_busy falls.
- tx_data never changes outside LOAD.
- If tx_busy is already 1 in IDLE (a foreign launch), the block waits until it clears.

Optional Feature:
Macro UART_TXQ_OVF_EN.
- Defined: ovf is set on the cycle after any dropped write and stays set until ovf_clr=1. Clear wins over a set in the same cycle.
- Not defined: ovf is constant 0, ovf_clr is ignored, and no flop is generated.
- Drop behaviour is identical in both cases.

Decomposition:
- Package uart_txq_pkg holds:
  - the state enum (IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_DONE, GAP);
  - default constants for STROBE_CYC, START_TIMEOUT and GAP_CYC;
  - the byte width constant (8).
- Sub-module uart_byte_fifo: synchronous single-clock FIFO with wr/rd, full, empty and count.
- The sequencer stays in the top module.

Test Plan:
- Write 8'hA5 into an empty queue, with the bench transmitter model at 16 clk/bit -> tx_wrsig rises 3 cycles later for 2 cycles, tx_data=8'hA5 held through the frame, and the serial line shows 0,A5 LSB-first,parity,1.
- Burst-write 8'h01..8'h10 (16 bytes) -> full=1 after the 16th write, count=16, then bytes transmitted in order 01..10. Each strobe follows tx_busy falling by 5 cycles.
- Write a 17th byte while full -> byte dropped. ovf=1 with the macro defined, ovf=0 without. ovf_clr=1 clears it.
- Hold tx_busy at 0 (model unresponsive) after a strobe -> re-strobe after 8 cycles, with a low cycle between strobes, same tx_data, and count unchanged.
- Assert rst_n=0 during WAIT_DONE with 5 bytes queued -> all outputs return to reset values immediately. After release, no strobe occurs until a new write.
- Write and pop in the same cycle with count=3 -> count stays 3. Write and pop in the same cycle at full=1 -> write dropped, count=15.
